instr_fetch_unit: RTL and testbench

- Instruction fetch stage that sits directly upstream of the execute/write stages of the non-pipelined RISC core.
- Issues word reads to instruction memory over a req/ack handshake with variable latency, and buffers fetched words with their PCs in a small prefetch queue.
- Presents one instruction per cycle to the consumer over a valid/ready interface.
- Handles branch redirects (queue flush plus in-flight discard) and stops fetching after an HLT opcode.

---
 rtl/instr_fetch_unit.sv | 109 ++++++++++
 tb/tb_instr_fetch_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch with prefetch queue, redirect discard and HLT stop
module instr_fetch_unit #(
    parameter int WIDTH      = 32,
    parameter int ADDRSIZE   = 12,
    parameter int DEPTH      = 4,
    parameter int RESET_PC   = 0,
    parameter logic [3:0] HLT_OPCODE = 4'b1001
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [ADDRSIZE-1:0]        imem_addr,
    input  logic                       imem_ack,
    input  logic [WIDTH-1:0]           imem_rdata,
    input  logic                       redirect_valid,
    input  logic [ADDRSIZE-1:0]        redirect_pc,
    output logic                       ir_valid,
    input  logic                       ir_ready,
    output logic [WIDTH-1:0]           ir_data,
    output logic [ADDRSIZE-1:0]        ir_pc,
    output logic                       fetch_halted,
    output logic [$clog2(DEPTH):0]     q_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [ADDRSIZE-1:0] RESET_ADDR = ADDRSIZE'(RESET_PC);

    logic [WIDTH-1:0]    data_q [DEPTH];
    logic [ADDRSIZE-1:0] pc_q   [DEPTH];
    logic [PW-1:0]       rd_ptr, wr_ptr;
    logic [CW-1:0]       count;
    logic [ADDRSIZE-1:0] pc;
    logic                discard;
    logic                halted;

    logic                xfer, held, push, pop;
    logic [CW-1:0]       count_next;
    logic [ADDRSIZE-1:0] pc_next;
    logic                halted_next;
    logic                req_next;

    assign ir_valid     = (count != '0);
    assign ir_data      = ir_valid ? data_q[rd_ptr] : '0;
    assign ir_pc        = ir_valid ? pc_q[rd_ptr] : '0;
    assign fetch_halted = halted;
    assign q_count      = count;

    // A redirect cancels both the push and the pop of its own cycle.
    always_comb begin
        xfer        = imem_req & imem_ack;
        held        = imem_req & ~imem_ack;
        push        = xfer & ~discard & ~redirect_valid;
        pop         = ir_valid & ir_ready & ~redirect_valid;
        count_next  = count;
        pc_next     = pc;
        halted_next = halted;
        if (redirect_valid) begin
            count_next  = '0;
            pc_next     = redirect_pc;
            halted_next = 1'b0;
        end else begin
            count_next = count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
            if (push) begin
                pc_next = pc + ADDRSIZE'(1);
                if (imem_rdata[WIDTH-1:WIDTH-4] == HLT_OPCODE)
                    halted_next = 1'b1;
            end
        end
        // An un-acked request must stay up with its address; otherwise issue only
        // when the queue still has room for the word it would bring back.
        req_next = held | (~halted_next & (count_next < DEPTH_C));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc        <= RESET_ADDR;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            discard   <= 1'b0;
            halted    <= 1'b0;
            imem_req  <= 1'b0;
            imem_addr <= RESET_ADDR;
        end else begin
            if (redirect_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    data_q[wr_ptr] <= imem_rdata;
                    pc_q[wr_ptr]   <= imem_addr;
                    wr_ptr         <= wr_ptr + PW'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
            end
            count  <= count_next;
            pc     <= pc_next;
            halted <= halted_next;
            // The stale in-flight word is marked for dropping when it finally returns.
            discard   <= redirect_valid ? held : (discard & ~xfer);
            imem_req  <= req_next;
            imem_addr <= held ? imem_addr : pc_next;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized bench for instr_fetch_unit against a scoreboard model
module tb_instr_fetch_unit;

    localparam int DEPTH = 4;
    localparam logic [11:0] RESET_PC = 12'h000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [11:0] redirect_pc = '0;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic [31:0] ir_data;
    logic [11:0] ir_pc;
    logic        fetch_halted;
    logic [2:0]  q_count;

    always #5 clk = ~clk;

    instr_fetch_unit #(.WIDTH(32), .ADDRSIZE(12), .DEPTH(DEPTH), .RESET_PC(0), .HLT_OPCODE(4'b1001)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_data(ir_data), .ir_pc(ir_pc),
        .fetch_halted(fetch_halted), .q_count(q_count)
    );

    typedef struct {
        logic [11:0] pc;
        logic [31:0] data;
    } entry_t;

    entry_t      mq[$];
    logic [11:0] m_fetch = RESET_PC;
    bit          m_halted = 0;
    bit          m_drop = 0;
    int          lat_cnt = -1;

    int n_checks = 0;
    int n_pass = 0;

    int min_lat = 0, max_lat = 0, p_ready = 100, p_redir = 0, p_rst = 0;
    bit hlt_rand = 0, hlt_at_en = 0, hold_rst = 0, force_rst_at3 = 0;
    logic [11:0] hlt_at = '0;
    int force_mode = 0;
    logic [11:0] force_rpc = '0, force_at = '0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mem_word(logic [11:0] a);
        if ((hlt_at_en && a == hlt_at) || (hlt_rand && a[4:0] == 5'd19))
            return 32'h9000_0000 | {20'h0, a};
        return {20'h0, a} + 32'h100;
    endfunction

    task automatic cycle();
        logic        s_req, s_valid, rst_in, ack_in, rdy_in, redir_in, held;
        logic [11:0] s_addr, rpc_in;
        logic [2:0]  s_cnt;
        logic [31:0] rd_in;
        s_req = imem_req; s_addr = imem_addr; s_valid = ir_valid; s_cnt = q_count;
        ack_in = 1'b0;
        rd_in  = $urandom;
        if (s_req === 1'b1) begin
            if (lat_cnt < 0) lat_cnt = $urandom_range(max_lat, min_lat);
            if (lat_cnt == 0) begin
                ack_in = 1'b1;
                rd_in = mem_word(s_addr);
                lat_cnt = -1;
            end else lat_cnt--;
        end else lat_cnt = -1;
        rdy_in   = ($urandom_range(99) < p_ready);
        redir_in = ($urandom_range(999) < p_redir);
        rpc_in   = ($urandom_range(3) == 0) ? 12'hFFE : 12'($urandom);
        if ((force_mode == 1) || (force_mode == 2 && s_req && !ack_in && s_addr == force_at)) begin
            redir_in = 1'b1;
            rpc_in = force_rpc;
            force_mode = 0;
        end
        rst_in = !(hold_rst || ($urandom_range(999) < p_rst));
        if (force_rst_at3 && s_cnt == 3'd3) begin
            rst_in = 1'b0;
            force_rst_at3 = 0;
        end
        if (!rst_in) lat_cnt = -1;
        reset = rst_in; imem_ack = ack_in; imem_rdata = rd_in;
        ir_ready = rdy_in; redirect_valid = redir_in; redirect_pc = rpc_in;
        @(posedge clk);
        @(negedge clk);
        if (!rst_in) begin
            mq.delete(); m_fetch = RESET_PC; m_halted = 0; m_drop = 0;
        end else if (redir_in) begin
            m_drop = s_req && !ack_in;
            mq.delete(); m_fetch = rpc_in; m_halted = 0;
        end else begin
            if (s_valid && rdy_in && mq.size() > 0) void'(mq.pop_front());
            if (s_req && ack_in) begin
                if (m_drop) m_drop = 0;
                else begin
                    mq.push_back('{pc: m_fetch, data: mem_word(m_fetch)});
                    if (mem_word(m_fetch) >> 28 == 32'h9) m_halted = 1;
                    m_fetch = m_fetch + 12'd1;
                end
            end
        end
        held = rst_in && s_req && !ack_in;
        check("q_count", q_count, mq.size());
        check("ir_valid", ir_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            check("ir_pc", ir_pc, mq[0].pc);
            check("ir_data", ir_data, mq[0].data);
        end
        check("fetch_halted", fetch_halted, m_halted);
        check("imem_req", imem_req, rst_in && (held || (!m_halted && mq.size() < DEPTH)));
        if (held) check("addr_hold", imem_addr, s_addr);
        else if (imem_req) check("req_addr", imem_addr, m_fetch);
        if (!rst_in) begin
            check("rst_addr", imem_addr, RESET_PC);
            check("rst_ir_data", ir_data, 0);
            check("rst_ir_pc", ir_pc, 0);
        end
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        hold_rst = 1; run(2); hold_rst = 0;
    endtask

    initial begin
        // Zero-wait streaming from reset.
        do_reset();
        run(30);
        // Consumer stalled: queue fills to DEPTH and fetch stops, then resumes.
        p_ready = 0; run(12);
        check("fill_count", q_count, 4);
        check("fill_req", imem_req, 0);
        p_ready = 100; run(20);
        // Redirect while address 5 is outstanding on a 3-cycle memory.
        p_ready = 100; do_reset();
        min_lat = 3; max_lat = 3;
        force_mode = 2; force_at = 12'h005; force_rpc = 12'h200;
        run(40);
        check("redir_fired", force_mode, 0);
        min_lat = 0; max_lat = 0;
        // HLT at address 3, then restart by redirect.
        hlt_at_en = 1; hlt_at = 12'h003; do_reset();
        run(20);
        check("hlt_halted", fetch_halted, 1);
        check("hlt_no_req", imem_req, 0);
        hlt_at_en = 0;
        force_mode = 1; force_rpc = 12'h010; run(20);
        check("hlt_restart", fetch_halted, 0);
        // PC wrap.
        force_mode = 1; force_rpc = 12'hFFE; run(12);
        // Reset with three words queued.
        do_reset(); p_ready = 0; force_rst_at3 = 1; run(10);
        check("rst3_fired", force_rst_at3, 0);
        // Random mix of latency, back-pressure, redirects, resets and halts.
        p_ready = 70; min_lat = 0; max_lat = 3; p_redir = 30; p_rst = 5; hlt_rand = 1;
        do_reset();
        run(3000);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
